// File: rtl/guess_game_ctrl.sv
// Round controller for guess_FSM: enable tick, button edge/priority capture,
// round pacing with verdict timeout, and score/round bookkeeping.
module guess_game_ctrl #(
    parameter int unsigned DIV           = 4,
    parameter int unsigned MAX_ROUNDS    = 8,
    parameter int unsigned HOLD_TICKS    = 2,
    parameter int unsigned TIMEOUT_TICKS = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn,
    output logic             fsm_en,
    output logic             fsm_rst,
    output logic [3:0]       fsm_in,
    input  logic             fsm_win,
    input  logic             fsm_lose,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] lose_cnt,
    output logic [CNT_W-1:0] round,
    output logic             busy,
    output logic             game_over
);

    localparam int unsigned DivW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned TmrMax = (HOLD_TICKS > TIMEOUT_TICKS) ? HOLD_TICKS : TIMEOUT_TICKS;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StPresent,
        StWait,
        StResult,
        StOver
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [3:0]        btn_q;
    logic [3:0]        pending_q, pending_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  lose_q, lose_d;
    logic [CNT_W-1:0]  round_q, round_d;
    logic              restart_q, restart_d;

    logic              tick;
    logic [3:0]        btn_edge;
    logic [3:0]        pick;
    logic [CNT_W-1:0]  round_inc;

    assign tick      = (div_q == DivW'(DIV - 1));
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign btn_edge  = btn & ~btn_q;
    // Two's-complement trick isolates the lowest set bit: bit0 has top priority.
    assign pick      = btn_edge & (~btn_edge + 4'd1);
    assign round_inc = round_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tmr_d     = tmr_q;
        win_d     = win_q;
        lose_d    = lose_q;
        round_d   = round_q;
        restart_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|btn_edge) state_d = StPlay;
            end
            StPlay: begin
                if (|btn_edge) begin
                    pending_d = pick;
                    state_d   = StPresent;
                end
            end
            StPresent: begin
                if (tick) begin
                    pending_d = '0;
                    tmr_d     = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (fsm_win) begin
                    if (win_q != '1) win_d = win_q + 1'b1;
                    tmr_d   = '0;
                    state_d = StResult;
                end else if (fsm_lose) begin
                    if (lose_q != '1) lose_d = lose_q + 1'b1;
                    tmr_d   = '0;
                    state_d = StResult;
                end else if (tick) begin
                    if (tmr_q == TmrW'(TIMEOUT_TICKS - 1)) begin
                        if (lose_q != '1) lose_d = lose_q + 1'b1;
                        tmr_d   = '0;
                        state_d = StResult;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            StResult: begin
                if (tick) begin
                    if (tmr_q == TmrW'(HOLD_TICKS - 1)) begin
                        round_d = round_inc;
                        tmr_d   = '0;
                        state_d = (round_inc == CNT_W'(MAX_ROUNDS)) ? StOver : StPlay;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            StOver: begin
                if (|btn_edge) begin
                    win_d     = '0;
                    lose_d    = '0;
                    round_d   = '0;
                    restart_d = 1'b1;
                    state_d   = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            btn_q     <= '0;
            pending_q <= '0;
            tmr_q     <= '0;
            win_q     <= '0;
            lose_q    <= '0;
            round_q   <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            btn_q     <= btn;
            pending_q <= pending_d;
            tmr_q     <= tmr_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            round_q   <= round_d;
            restart_q <= restart_d;
        end
    end

    assign fsm_en    = tick;
    assign fsm_rst   = (state_q == StIdle) | restart_q;
    assign fsm_in    = (state_q == StPresent) ? pending_q : 4'b0000;
    assign busy      = (state_q == StPresent) | (state_q == StWait) | (state_q == StResult);
    assign game_over = (state_q == StOver);
    assign win_cnt   = win_q;
    assign lose_cnt  = lose_q;
    assign round     = round_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with DIV=4, MAX_ROUNDS=3, HOLD_TICKS=2, TIMEOUT_TICKS=4.
module tb_guess_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       fsm_en, fsm_rst, fsm_win, fsm_lose, busy, game_over;
    logic [3:0] fsm_in, win_cnt, lose_cnt, round;

    int n_tests = 0;
    int n_fail  = 0;

    guess_game_ctrl #(
        .DIV          (4),
        .MAX_ROUNDS   (3),
        .HOLD_TICKS   (2),
        .TIMEOUT_TICKS(4),
        .CNT_W        (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .fsm_en   (fsm_en),
        .fsm_rst  (fsm_rst),
        .fsm_in   (fsm_in),
        .fsm_win  (fsm_win),
        .fsm_lose (fsm_lose),
        .win_cnt  (win_cnt),
        .lose_cnt (lose_cnt),
        .round    (round),
        .busy     (busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until an fsm_en cycle is being sampled, bounded.
    task automatic wait_en();
        int n = 0;
        while (!fsm_en && n < 20) begin
            step();
            n++;
        end
        if (!fsm_en) check_eq("en_timeout", 32'(fsm_en), 32'd1);
    endtask

    task automatic hold_result();
        wait_en();
        step();
        wait_en();
        step();
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step();
        btn = 4'b0000;
    endtask

    initial begin
        rst      = 1'b1;
        btn      = 4'b0000;
        fsm_win  = 1'b0;
        fsm_lose = 1'b0;

        // 1. reset then idle
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_fsm_rst", 32'(fsm_rst), 32'd1);
        check_eq("rst_fsm_in", 32'(fsm_in), 32'd0);
        check_eq("rst_en", 32'(fsm_en), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_cnts", {20'd0, win_cnt, lose_cnt, round}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("en_period_%0d", i), 32'(fsm_en), 32'((i % 4) == 2));
        end
        check_eq("idle_fsm_rst", 32'(fsm_rst), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // 2. start and win
        press(4'b0001);
        check_eq("start_fsm_rst", 32'(fsm_rst), 32'd0);
        check_eq("start_not_guess", 32'(busy), 32'd0);
        step();
        press(4'b0010);
        check_eq("g1_fsm_in", 32'(fsm_in), 32'h2);
        check_eq("g1_busy", 32'(busy), 32'd1);
        wait_en();
        check_eq("g1_in_at_en", 32'(fsm_in), 32'h2);
        step();
        check_eq("g1_in_removed", 32'(fsm_in), 32'h0);
        step();
        fsm_win = 1'b1;
        step();
        fsm_win = 1'b0;
        check_eq("g1_win_cnt", 32'(win_cnt), 32'd1);
        check_eq("g1_round_pending", 32'(round), 32'd0);
        check_eq("g1_busy_result", 32'(busy), 32'd1);
        hold_result();
        check_eq("g1_round", 32'(round), 32'd1);
        check_eq("g1_busy_done", 32'(busy), 32'd0);

        // 3. simultaneous presses, late edge while pending, held buttons
        btn = 4'b0110;
        step();
        check_eq("g2_priority", 32'(fsm_in), 32'h2);
        btn = 4'b1110;
        step();
        check_eq("g2_late_edge", 32'(fsm_in), 32'h2);
        wait_en();
        check_eq("g2_in_at_en", 32'(fsm_in), 32'h2);
        step();
        fsm_lose = 1'b1;
        step();
        fsm_lose = 1'b0;
        check_eq("g2_lose_cnt", 32'(lose_cnt), 32'd1);
        check_eq("g2_win_cnt", 32'(win_cnt), 32'd1);
        hold_result();
        check_eq("g2_round", 32'(round), 32'd2);
        repeat (6) step();
        check_eq("g2_held_no_guess", 32'(busy), 32'd0);
        check_eq("g2_held_fsm_in", 32'(fsm_in), 32'h0);
        btn = 4'b0000;
        step();

        // 4a. timeout round, ends the game
        press(4'b0100);
        check_eq("g3_fsm_in", 32'(fsm_in), 32'h4);
        wait_en();
        step();
        for (int t = 0; t < 3; t++) begin
            wait_en();
            step();
        end
        check_eq("g3_before_timeout", 32'(lose_cnt), 32'd1);
        check_eq("g3_still_busy", 32'(busy), 32'd1);
        wait_en();
        step();
        check_eq("g3_timeout_lose", 32'(lose_cnt), 32'd2);
        hold_result();

        // 5. game over and restart
        check_eq("over_flag", 32'(game_over), 32'd1);
        check_eq("over_round", 32'(round), 32'd3);
        check_eq("over_lose", 32'(lose_cnt), 32'd2);
        check_eq("over_win", 32'(win_cnt), 32'd1);
        check_eq("over_fsm_rst", 32'(fsm_rst), 32'd0);
        fsm_win = 1'b1;
        step();
        step();
        fsm_win = 1'b0;
        check_eq("over_verdict_ignored", 32'(win_cnt), 32'd1);
        press(4'b0001);
        check_eq("restart_cnts", {20'd0, win_cnt, lose_cnt, round}, 32'd0);
        check_eq("restart_pulse", 32'(fsm_rst), 32'd1);
        check_eq("restart_over_clr", 32'(game_over), 32'd0);
        check_eq("restart_not_guess", 32'(busy), 32'd0);
        step();
        check_eq("restart_pulse_end", 32'(fsm_rst), 32'd0);
        check_eq("restart_still_idle", 32'(busy), 32'd0);

        // 4b. win and lose together: win has priority
        press(4'b1000);
        check_eq("g4_fsm_in", 32'(fsm_in), 32'h8);
        wait_en();
        step();
        fsm_win  = 1'b1;
        fsm_lose = 1'b1;
        step();
        fsm_win  = 1'b0;
        fsm_lose = 1'b0;
        check_eq("g4_win", 32'(win_cnt), 32'd1);
        check_eq("g4_lose", 32'(lose_cnt), 32'd0);
        hold_result();
        check_eq("g4_round", 32'(round), 32'd1);

        // 6. async reset mid-round
        press(4'b0001);
        check_eq("g5_fsm_in", 32'(fsm_in), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_fsm_in", 32'(fsm_in), 32'h0);
        check_eq("arst_fsm_rst", 32'(fsm_rst), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_cnts", {20'd0, win_cnt, lose_cnt, round}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        step();
        check_eq("arst_idle_rst", 32'(fsm_rst), 32'd1);
        check_eq("arst_idle_in", 32'(fsm_in), 32'h0);
        press(4'b0010);
        check_eq("arst_start_fsm_rst", 32'(fsm_rst), 32'd0);
        check_eq("arst_start_not_guess", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
